fetch_queue: RTL
================

# fetch_queue

Decoupling queue between the instruction-fetch stage and decode. It accepts one fetch packet per cycle over a valid/ready handshake. Each packet holds IF_WIDTH instruction lanes from one aligned fetch block. On enqueue the queue masks out lanes that sit before the packet PC (for example after a redirect into the middle of a block) and drops packets left with no valid lanes. Surviving packets are delivered in order to decode over a second valid/ready handshake. A backend flush empties the queue in one cycle.

## Interface
Parameters:
- IF_WIDTH, 2: instruction lanes per packet; power of two, ≥1.
- DEPTH, 8: packet entries; power of two, ≥2.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  backend flush; discards all entries.
- in_valid  in  1  fetch packet offered.
- in_ready  out  1  queue can take a packet.
- in_pc  in  32  PC of the packet; may be unaligned within the block.
- in_inst  in  IF_WIDTH×32  lane i instruction.
- in_lane_valid  in  IF_WIDTH  raw lane valid bits.
- in_predict_taken  in  IF_WIDTH  per-lane prediction.
- in_predict_target  in  IF_WIDTH×32  per-lane predicted next PC.
- out_valid  out  1  head packet available.
- out_ready  in  1  decode consumes the head.
- out_pc, out_inst, out_lane_valid, out_predict_taken, out_predict_target  out  same widths as the inputs  head packet fields.
- occupancy  out  $clog2(DEPTH)+1  number of stored packets.

## Operation
- Storage is a circular buffer of DEPTH entries.
  - Read pointer and write pointer are each $clog2(DEPTH)+1 bits; the MSB is a wrap bit.
  - empty = pointers equal.
  - full = low bits equal and wrap bits differ.
  - occupancy = wptr − rptr, modulo 2^($clog2(DEPTH)+1).
- Lane masking uses OFF = in_pc[$clog2(IF_WIDTH)+1:2]; OFF = 0 when IF_WIDTH = 1.
  - masked[i] = in_lane_valid[i] && (i ≥ OFF).
  - Only the masked lane-valid vector is stored.
- Enqueue fire = in_valid && in_ready.
  - If masked ≠ 0: write the entry (pc, inst, masked, predict_taken, predict_target) at wptr, then wptr+1.
  - If masked = 0: the packet is accepted and discarded; no write, no pointer change.
- in_ready = !full && !rst.
  - Enqueue into a full queue is never accepted, even when a dequeue happens in the same cycle.
- Dequeue fire = out_valid && out_ready; then rptr+1.
- out_valid = !empty. Output fields come combinationally from the entry at rptr.
  - out_lane_valid is forced to 0 when the queue is empty.
- Simultaneous enqueue and dequeue on a non-full queue: both complete; occupancy is unchanged.
- Flush has priority over enqueue and dequeue in the same cycle.
  - Both pointers go to 0 on the next edge; the incoming packet and the head are discarded.
  - in_ready is not gated by flush, so the upstream stage sees its packet as accepted and discarded.
- Pointer arithmetic wraps naturally at 2^($clog2(DEPTH)+1); no other saturation.
- Storage entries are not reset; only pointers are.

## Timing
- Reset (asynchronous assert): rptr = wptr = 0 immediately, regardless of clk. Resulting output values:
  - out_valid = 0, out_lane_valid = 0
  - occupancy = 0, in_ready = 0
- After reset release: in_ready = 1 in the same cycle, once rst is low.
- Reset mid-operation: all packets are lost; no partial entry is visible.
- Enqueue-to-out_valid latency: 1 cycle. A packet written at edge N is visible after edge N; there is no same-cycle bypass from empty.
- Flush: out_valid = 0 after the flush edge. A new enqueue in the following cycle is visible one cycle later.
- Throughput: one packet in and one out per cycle at steady state (occupancy between 1 and DEPTH−1).

## Test plan
- Reset, then enqueue packet pc=0x1eceb000, lanes 2'b11, with out_ready=0:
  - occupancy 0→1, out_valid=1, out_pc=0x1eceb000, out_lane_valid=2'b11.
  - Assert out_ready: occupancy returns to 0 and out_valid=0.
- Redirect masking (IF_WIDTH=2): enqueue pc=0x1eceb004, lanes 2'b11 → stored out_lane_valid=2'b10.
  - Enqueue pc=0x1eceb004, lanes 2'b01 → in_ready=1, occupancy unchanged, nothing appears at the output.
- Fill (DEPTH=4), out_ready=0: enqueue pcs 0x0, 0x8, 0x10, 0x18 → occupancy 4, in_ready=0.
  - A fifth offered packet (0x20) is held.
  - Pulse one dequeue: the 0x20 enqueue is accepted only in the following cycle.
  - Output order is 0x0, 0x8, 0x10, 0x18, 0x20.
- Wrap-around: stream 20 packets with in_valid and out_ready held high → output pcs stay in order, occupancy stays at 1 after the first packet, no drops.
- Flush coincident with enqueue and dequeue at occupancy 3 → next cycle occupancy 0 and out_valid 0; the concurrent input packet never appears.
- Asynchronous reset asserted between edges at occupancy 2 → out_valid and occupancy drop to 0 before the next clk edge.

Source files
------------

// File: rtl/fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue_if
// Description : Fetch-packet valid/ready bundle. One packet carries IF_WIDTH
//               instruction lanes from a single aligned fetch block.
//               master drives valid and the packet fields; slave drives ready.
// Signals     : valid, ready, pc[31:0], inst[IF_WIDTH*32], lane_valid,
//               predict_taken, predict_target[IF_WIDTH*32]
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_queue_if #(
  parameter int IF_WIDTH = 2
);
  logic                     valid;
  logic                     ready;
  logic [31:0]              pc;
  logic [IF_WIDTH*32-1:0]   inst;
  logic [IF_WIDTH-1:0]      lane_valid;
  logic [IF_WIDTH-1:0]      predict_taken;
  logic [IF_WIDTH*32-1:0]   predict_target;

  modport master (
    output valid, pc, inst, lane_valid, predict_taken, predict_target,
    input  ready
  );

  modport slave (
    input  valid, pc, inst, lane_valid, predict_taken, predict_target,
    output ready
  );
endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Decoupling queue between instruction fetch and decode.
//               Lanes before the packet PC are masked off on enqueue; packets
//               left with no valid lanes are accepted and dropped. Surviving
//               packets leave in order. Flush empties the queue in one cycle.
// Ports       : clk       - clock, rising edge
//               rst       - asynchronous active-high reset
//               flush     - discard all entries (beats enqueue/dequeue)
//               in_if     - fetch packet input (slave side)
//               out_if    - head packet output to decode (master side)
//               occupancy - number of stored packets
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
  parameter int IF_WIDTH = 2,
  parameter int DEPTH    = 8
) (
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic               flush,
  fetch_queue_if.slave            in_if,
  fetch_queue_if.master           out_if,
  output logic [$clog2(DEPTH):0]  occupancy
);

  localparam int          AW      = $clog2(DEPTH);
  localparam int          OFFW    = (IF_WIDTH > 1) ? $clog2(IF_WIDTH) : 1;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Pointers carry an extra wrap bit to tell full from empty.
  logic [AW:0]            r_rptr;
  logic [AW:0]            r_wptr;

  logic [31:0]            r_mem_pc     [DEPTH];
  logic [IF_WIDTH*32-1:0] r_mem_inst   [DEPTH];
  logic [IF_WIDTH-1:0]    r_mem_lv     [DEPTH];
  logic [IF_WIDTH-1:0]    r_mem_pt     [DEPTH];
  logic [IF_WIDTH*32-1:0] r_mem_ptg    [DEPTH];

  logic                   w_empty;
  logic                   w_full;
  logic [OFFW-1:0]        w_off;
  logic [IF_WIDTH-1:0]    w_masked;
  logic                   w_enq_fire;
  logic                   w_enq_write;
  logic                   w_deq_fire;
  logic [AW-1:0]          w_head;

  assign w_empty = (r_rptr == r_wptr);
  assign w_full  = (r_rptr[AW-1:0] == r_wptr[AW-1:0]) && (r_rptr[AW] != r_wptr[AW]);

  // Full blocks enqueue even if the head leaves this same cycle.
  assign in_if.ready = !w_full && !rst;

  // Lane offset of the PC within its aligned fetch block.
  if (IF_WIDTH > 1) begin : g_off_multi
    assign w_off = in_if.pc[$clog2(IF_WIDTH)+1:2];
  end else begin : g_off_single
    assign w_off = '0;
  end

  for (genvar gi = 0; gi < IF_WIDTH; gi++) begin : g_mask
    assign w_masked[gi] = in_if.lane_valid[gi] && (OFFW'(gi) >= w_off);
  end

  assign w_enq_fire  = in_if.valid && in_if.ready;
  // Empty-after-mask packets are consumed without taking a slot.
  assign w_enq_write = w_enq_fire && (|w_masked) && !flush;
  assign w_deq_fire  = out_if.valid && out_if.ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rptr <= '0;
      r_wptr <= '0;
    end else if (flush) begin
      r_rptr <= '0;
      r_wptr <= '0;
    end else begin
      if (w_enq_write) r_wptr <= r_wptr + PTR_ONE;
      if (w_deq_fire)  r_rptr <= r_rptr + PTR_ONE;
    end
  end

  // Payload storage carries no reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (w_enq_write) begin
      r_mem_pc [r_wptr[AW-1:0]] <= in_if.pc;
      r_mem_inst[r_wptr[AW-1:0]] <= in_if.inst;
      r_mem_lv [r_wptr[AW-1:0]] <= w_masked;
      r_mem_pt [r_wptr[AW-1:0]] <= in_if.predict_taken;
      r_mem_ptg[r_wptr[AW-1:0]] <= in_if.predict_target;
    end
  end

  assign w_head = r_rptr[AW-1:0];

  assign out_if.valid          = !w_empty;
  assign out_if.pc             = r_mem_pc[w_head];
  assign out_if.inst           = r_mem_inst[w_head];
  assign out_if.lane_valid     = w_empty ? '0 : r_mem_lv[w_head];
  assign out_if.predict_taken  = r_mem_pt[w_head];
  assign out_if.predict_target = r_mem_ptg[w_head];

  assign occupancy = r_wptr - r_rptr;

endmodule
`default_nettype wire
